// File: rtl/if_id_stage.sv
// IF/ID pipeline boundary: registered PC/instruction with valid/ready handshake, flush and
// immediate-field slicing. Define IFID_SKID_EN to add the one-entry skid buffer.
module if_id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  output logic        if_ready,
  input  logic        flush,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_instr,
  output logic [11:0] id_iimm,
  output logic [4:0]  id_shamt,
  output logic [11:0] id_simm,
  output logic [11:0] id_bimm,
  output logic [19:0] id_uimm,
  output logic [19:0] id_jimm
);

  logic        main_valid_q, main_valid_d;
  logic [31:0] main_pc_q, main_pc_d;
  logic [31:0] main_instr_q, main_instr_d;
  logic        accept;
  logic        consume;

`ifdef IFID_SKID_EN
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  // Ready depends on registered state only, so id_ready never reaches fetch combinationally.
  assign if_ready = !skid_valid_q;
`else
  assign if_ready = !main_valid_q | id_ready;
`endif

  assign consume = main_valid_q & id_ready;
  assign accept  = if_valid & if_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
`ifdef IFID_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
`endif
    if (flush) begin
      main_valid_d = 1'b0;
      main_pc_d    = RESET_PC;
      main_instr_d = NOP_INSTR;
`ifdef IFID_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end
`ifdef IFID_SKID_EN
    else if (skid_valid_q && consume) begin
      main_pc_d    = skid_pc_q;
      main_instr_d = skid_instr_q;
      skid_valid_d = 1'b0;
    end
`endif
    else if (accept && (!main_valid_q || consume)) begin
      main_valid_d = 1'b1;
      main_pc_d    = if_pc;
      main_instr_d = if_instr;
    end else if (consume) begin
      main_valid_d = 1'b0;
    end
`ifdef IFID_SKID_EN
    else if (accept) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = if_pc;
      skid_instr_d = if_instr;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= RESET_PC;
      main_instr_q <= NOP_INSTR;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
    end
  end

`ifdef IFID_SKID_EN
  always_ff @(posedge clk) begin
    if (rst) skid_valid_q <= 1'b0;
    else     skid_valid_q <= skid_valid_d;
    skid_pc_q    <= skid_pc_d;
    skid_instr_q <= skid_instr_d;
  end
`endif

  // Decode-side view: an empty stage presents a NOP so the fields are always well defined.
  assign id_valid = main_valid_q;
  assign id_pc    = main_pc_q;
  assign id_pc4   = main_pc_q + 32'd4;
  assign id_instr = main_valid_q ? main_instr_q : NOP_INSTR;
  assign id_iimm  = id_instr[31:20];
  assign id_shamt = id_instr[24:20];
  assign id_simm  = {id_instr[31:25], id_instr[11:7]};
  assign id_bimm  = {id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8]};
  assign id_uimm  = id_instr[31:12];
  assign id_jimm  = {id_instr[31], id_instr[19:12], id_instr[20], id_instr[30:21]};

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: queue-based occupancy model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with flush/reset.
module tb_if_id_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] RPC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, id_ready;
  logic [31:0] if_pc, if_instr;
  logic        if_ready, id_valid;
  logic [31:0] id_pc, id_pc4, id_instr;
  logic [11:0] id_iimm, id_simm, id_bimm;
  logic [4:0]  id_shamt;
  logic [19:0] id_uimm, id_jimm;

  if_id_stage #(.NOP_INSTR(NOP), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready), .flush(flush), .id_ready(id_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_pc4(id_pc4), .id_instr(id_instr), .id_iimm(id_iimm),
    .id_shamt(id_shamt), .id_simm(id_simm), .id_bimm(id_bimm), .id_uimm(id_uimm),
    .id_jimm(id_jimm)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: the stage is a FIFO of held instructions, head presented to decode.
  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];
  bit pristine = 1'b1;
  bit m_acc, m_con;

  function automatic bit m_if_ready();
`ifdef IFID_SKID_EN
    return q_pc.size() < 2;
`else
    return (q_pc.size() == 0) || id_ready;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst || flush) begin
      q_pc.delete();
      q_in.delete();
      pristine = 1'b1;
    end else begin
      m_acc = if_valid && m_if_ready();
      m_con = (q_pc.size() > 0) && id_ready;
      if (m_con) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      if (m_acc) begin
        q_pc.push_back(if_pc);
        q_in.push_back(if_instr);
        pristine = 1'b0;
      end
    end
  end

  logic [31:0] e_in, e_pc;
  always @(negedge clk) begin
    if (chk_en) begin
      e_in = (q_in.size() > 0) ? q_in[0] : NOP;
      check("id_valid", {31'd0, id_valid}, {31'd0, q_pc.size() > 0});
      check("if_ready", {31'd0, if_ready}, {31'd0, m_if_ready()});
      check("id_instr", id_instr, e_in);
      check("id_iimm",  {20'd0, id_iimm},  {20'd0, e_in[31:20]});
      check("id_shamt", {27'd0, id_shamt}, {27'd0, e_in[24:20]});
      check("id_simm",  {20'd0, id_simm},  {20'd0, e_in[31:25], e_in[11:7]});
      check("id_bimm",  {20'd0, id_bimm},  {20'd0, e_in[31], e_in[7], e_in[30:25], e_in[11:8]});
      check("id_uimm",  {12'd0, id_uimm},  {12'd0, e_in[31:12]});
      check("id_jimm",  {12'd0, id_jimm},  {12'd0, e_in[31], e_in[19:12], e_in[20], e_in[30:21]});
      if (q_pc.size() > 0 || pristine) begin
        e_pc = (q_pc.size() > 0) ? q_pc[0] : RPC;
        check("id_pc",  id_pc,  e_pc);
        check("id_pc4", id_pc4, e_pc + 32'd4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                       input bit rdy, input bit fl, input bit r);
    if_valid = v; if_pc = pc; if_instr = ins; id_ready = rdy; flush = fl; rst = r;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk_en = 1'b1;
    tick();
    // Reset state
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_instr", id_instr, 32'h0000_0013);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_pc4", id_pc4, 32'h4);
    check("rst_if_ready", {31'd0, if_ready}, 32'd1);
    check("rst_iimm", {20'd0, id_iimm}, 32'h0);

    // Streaming
    drive(1, 32'h100, 32'hFE01_0113, 1, 0, 0);
    tick();
    check("str_pc0", id_pc, 32'h100);
    check("str_iimm", {20'd0, id_iimm}, 32'hFE0);
    drive(1, 32'h104, 32'h0041_0093, 1, 0, 0);
    tick();
    check("str_pc1", id_pc, 32'h104);
    check("str_pc4", id_pc4, 32'h108);

    // Field slicing
    drive(1, 32'h108, 32'h8000_006F, 1, 0, 0);
    tick();
    check("jal_jimm", {12'd0, id_jimm}, 32'h80000);
    check("jal_uimm", {12'd0, id_uimm}, 32'h80000);
    drive(1, 32'h10C, 32'hFE00_0EE3, 1, 0, 0);
    tick();
    check("br_bimm", {20'd0, id_bimm}, 32'hFFE);
    check("br_simm", {20'd0, id_simm}, 32'hFFD);
    drive(0, 0, 0, 1, 0, 0);
    tick();
    check("drain_valid", {31'd0, id_valid}, 32'd0);

    // Stall behaviour
    drive(1, 32'h200, 32'h0010_0093, 0, 0, 0);
    tick();
    check("stall_pc", id_pc, 32'h200);
`ifdef IFID_SKID_EN
    drive(1, 32'h204, 32'h0020_0093, 0, 0, 0);
    tick();
    check("skid_full_ready", {31'd0, if_ready}, 32'd0);
    check("skid_hold_pc", id_pc, 32'h200);
    drive(0, 0, 0, 1, 0, 0);
    tick();
    check("skid_rel_pc", id_pc, 32'h204);
    check("skid_rel_valid", {31'd0, id_valid}, 32'd1);
    check("skid_rel_ready", {31'd0, if_ready}, 32'd1);
    tick();
    check("skid_empty", {31'd0, id_valid}, 32'd0);
    // Flush with both entries full
    drive(1, 32'h210, 32'h0030_0093, 0, 0, 0);
    tick();
    drive(1, 32'h214, 32'h0040_0093, 0, 0, 0);
    tick();
`else
    drive(1, 32'h204, 32'h0020_0093, 0, 0, 0);
    #1;
    check("ns_ready_lo", {31'd0, if_ready}, 32'd0);
    id_ready = 1'b1;
    #1;
    check("ns_ready_hi", {31'd0, if_ready}, 32'd1);
    tick();
    check("ns_replace_pc", id_pc, 32'h204);
    drive(1, 32'h210, 32'h0030_0093, 0, 0, 0);
    tick();
`endif
    drive(1, 32'h300, 32'h0050_0093, 1, 1, 0);
    tick();
    check("fl_valid", {31'd0, id_valid}, 32'd0);
    check("fl_ready", {31'd0, if_ready}, 32'd1);
    check("fl_instr", id_instr, 32'h0000_0013);
    drive(0, 0, 0, 1, 0, 0);
    tick();
    check("fl_no_300", {31'd0, id_valid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom % 4) != 0, {$urandom, 2'b00} >> 0, $urandom, ($urandom % 3) != 0,
            ($urandom % 50) == 0, ($urandom % 300) == 0);
      if_pc = {if_pc[31:2], 2'b00};
      tick();
    end
    drive(0, 0, 0, 1, 0, 0);
    tick();
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline boundary of the 5-stage core.
- Captures PC and instruction words from fetch and presents them to decode with a valid/ready handshake, flush and a one-entry skid buffer.
- Slices the registered instruction into the raw immediate fields that decode hands to the immediate extender, so the extender sees only registered inputs.

## Interface
Parameters:
- NOP_INSTR, 32'h0000_0013, instruction word presented when the stage holds no valid instruction (addi x0,x0,0)
- RESET_PC, 32'h0000_0000, value of id_pc after reset or flush

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- if_valid  input  1  fetch offers if_pc/if_instr this cycle
- if_pc  input  32  PC of offered instruction
- if_instr  input  32  offered instruction word
- if_ready  output  1  stage accepts an offer this cycle
- flush  input  1  squash all held instructions (branch/jump redirect from EX)
- id_ready  input  1  decode consumes the presented instruction this cycle (low = stall)
- id_valid  output  1  presented instruction is valid
- id_pc  output  32  PC of presented instruction
- id_pc4  output  32  id_pc + 4, modulo 2^32
- id_instr  output  32  presented instruction; NOP_INSTR when id_valid=0
- id_iimm  output  12  id_instr[31:20]
- id_shamt  output  5  id_instr[24:20]
- id_simm  output  12  {id_instr[31:25], id_instr[11:7]}
- id_bimm  output  12  {id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8]}
- id_uimm  output  20  id_instr[31:12]
- id_jimm  output  20  {id_instr[31], id_instr[19:12], id_instr[20], id_instr[30:21]}

## Operation
- Storage: main entry (pc, instr, valid) drives the id_* outputs; skid entry (pc, instr, valid) holds one overflow instruction.
- if_ready = !skid_valid (registered state only; no combinational path from id_ready).
- Accept = if_valid & if_ready. Consume = id_valid & id_ready.
- Per-cycle update, priority order:
  - rst: main_valid=0, skid_valid=0, main pc=RESET_PC, main instr=NOP_INSTR.
  - flush: same as reset. An offer made in the flush cycle is discarded, and so is the consume.
  - skid_valid & consume: skid moves into main; skid_valid=0. No accept is possible because if_ready=0.
  - !main_valid & accept: offer goes into main.
  - main_valid & consume & accept: offer replaces main.
  - main_valid & consume & !accept: main_valid=0.
  - main_valid & !consume & accept: offer goes into skid; skid_valid=1.
  - Otherwise: hold.
- No instruction is duplicated or dropped except by flush/reset. Order is preserved: skid always drains before new offers are accepted.
- Field outputs and id_pc4 are combinational from id_instr/id_pc.
  - When id_valid=0, the fields are those of NOP_INSTR, e.g. id_iimm=12'h000.

## Timing
- Latency: an instruction accepted at edge N appears on id_* after edge N, i.e. 1 cycle. When routed through the skid it appears 1 cycle after the stall releases.
- Throughput: 1 instruction/cycle when id_ready stays high.
- Reset values: id_valid=0, id_pc=RESET_PC, id_pc4=RESET_PC+4, id_instr=NOP_INSTR, if_ready=1.
- Full: skid_valid=1 means if_ready=0 in the next cycle. It returns to 1 the cycle after the first consume.
- Empty: id_valid=0 with id_ready high is legal and has no effect.
- Flush during stall with skid full: both entries cleared; if_ready=1 and id_valid=0 the next cycle.
- Reset asserted mid-stream behaves identically to flush.
- Simultaneous flush and rst: reset values apply; the two are identical in effect.

## Configuration
- IFID_SKID_EN defined: skid entry present, behaviour as above.
- IFID_SKID_EN undefined: no skid storage.
  - if_ready = !main_valid | id_ready. This adds a combinational path from id_ready to if_ready.
  - The "offer goes into skid" case cannot occur.
  - All other rules, reset values and latency are unchanged.

## Test plan
- Reset then idle: rst=1 for 2 cycles -> id_valid=0, id_instr=32'h00000013, id_pc=0, id_pc4=4, if_ready=1.
- Streaming: offer pc=0x100 instr=0xFE010113, then pc=0x104, with id_ready=1 -> id_pc=0x100 one cycle later and id_iimm=12'hFE0, then 0x104 the next cycle.
- Stall with skid (IFID_SKID_EN):
  - Main holds 0x200; id_ready=0; offer 0x204 -> skid fills and if_ready=0 next cycle.
  - Release id_ready -> 0x204 presented; if_ready=1 one cycle later.
  - 0x200 and 0x204 each consumed exactly once.
- Field slicing: instr 0x8000006F (jal with negative offset) -> id_jimm=20'h80000, id_uimm=20'h80000. Instr 0xFE000EE3 -> id_bimm=12'hFFE, id_simm=12'hFFD.
- Flush: main and skid full; assert flush with if_valid=1, offer 0x300 -> next cycle id_valid=0, if_ready=1, id_instr=NOP. 0x300 never appears.
- No-skid build: main full, id_ready=0 -> if_ready=0 in the same cycle. id_ready=1 -> if_ready=1 in the same cycle, and the offer replaces main.
